// File: rtl/gold_nic_pkg.sv
// gold_nic_pkg: shared constants for the gold_nic network interface.
//   - flit field bit positions (the NIC never modifies these fields, they are
//     listed so the PE-side software view and the RTL agree on the layout)
//   - PE register address codes
package gold_nic_pkg;

  // Flit layout: [63] vc, [62] dirX, [61] dirY, [60:56] reserved,
  // [55:52] hopX, [51:48] hopY, [47:0] payload
  localparam int VC_BIT   = 63;
  localparam int DIRX_BIT = 62;
  localparam int DIRY_BIT = 61;
  localparam int HOPX_MSB = 55;
  localparam int HOPX_LSB = 52;
  localparam int HOPY_MSB = 51;
  localparam int HOPY_LSB = 48;

  // PE register map
  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;  // read-only
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;  // read-only, bit0 = in_full
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;  // write-only
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;  // read-only, bit0 = out_full

endpackage

// File: rtl/gold_nic_chan_buf.sv
// nic_chan_buf: one-flit channel register with a full flag.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset (clears data and flag)
//   load         - capture d_in and set full
//   unload       - clear full (data is kept, a later read sees the stale flit)
//   d_in         - flit to capture
//   data         - stored flit
//   full         - buffer holds an unconsumed flit
// The parent only asserts load while empty and unload while full, so the two
// are never active together; load still takes priority for robustness.
module nic_chan_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  unload,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= d_in;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/gold_nic.sv
// gold_nic: network interface between a processing element and the NIC port
// of gold_router. One-flit output and input buffers are exposed to the PE as
// a 4-register memory-mapped interface.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   addr, d_in, d_out     - PE register select, write data, registered read data
//   nicEn, nicWrEn        - PE access enable, 1 = write / 0 = read
//   net_so, net_do        - send strobe and flit to router NIC input
//   net_ro                - router can accept a flit
//   net_si, net_di        - send strobe and flit from router NIC output
//   net_ri                - NIC can accept a flit
//   net_polarity          - router polarity; only flits whose vc matches inject
module gold_nic
  import gold_nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_ro,
  input  logic                  net_si,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_ri,
  input  logic                  net_polarity
);

  logic                  pe_rd;
  logic                  pe_wr;
  logic [DATA_WIDTH-1:0] in_buf;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] out_buf;
  logic                  out_full;
  logic                  in_load;
  logic                  in_unload;
  logic                  out_load;
  logic [DATA_WIDTH-1:0] rd_data;

  assign pe_rd = nicEn & ~nicWrEn;
  assign pe_wr = nicEn & nicWrEn;

  // Injection: a flit waits (indefinitely) until its vc bit matches polarity.
  assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
  assign net_do = out_buf;

  // Ejection: a strobe while full is a router protocol violation and is dropped.
  assign net_ri    = ~in_full;
  assign in_load   = net_si & net_ri;
  assign in_unload = pe_rd & (addr == ADDR_IN_BUF) & in_full;

  // A write while full (including the cycle of a send) is silently dropped.
  assign out_load  = pe_wr & (addr == ADDR_OUT_BUF) & ~out_full;

  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (in_load),
    .unload (in_unload),
    .d_in   (net_di),
    .data   (in_buf),
    .full   (in_full)
  );

  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (out_load),
    .unload (net_so),
    .d_in   (d_in),
    .data   (out_buf),
    .full   (out_full)
  );

  // Read mux samples pre-edge state, so a status read during a send returns 1.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_IN_BUF:   rd_data = in_buf;
      ADDR_IN_STAT:  rd_data = {{(DATA_WIDTH-1){1'b0}}, in_full};
      ADDR_OUT_STAT: rd_data = {{(DATA_WIDTH-1){1'b0}}, out_full};
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (pe_rd) begin
      d_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_gold_nic.sv
// tb_gold_nic: directed, table-driven bench for gold_nic. Each table row is
// driven on a falling edge; the combinational network outputs are compared
// before the next rising edge and d_out is compared just after it.
module tb_gold_nic;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ro;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ri;
  logic        net_polarity;

  int checks;
  int passes;

  gold_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_do       (net_do),
    .net_ro       (net_ro),
    .net_si       (net_si),
    .net_di       (net_di),
    .net_ri       (net_ri),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        we;
    logic [1:0]  a;
    logic [63:0] din;
    logic        ro;
    logic        pol;
    logic        si;
    logic [63:0] di;
    logic        exp_so;
    logic        exp_ri;
    logic [63:0] exp_ndo;
    logic [63:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] make_flit(input logic vc, input logic dx,
                                            input logic dy, input logic [3:0] hx,
                                            input logic [3:0] hy,
                                            input logic [47:0] pl);
    return {vc, dx, dy, 5'b0, hx, hy, pl};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic en, input logic we, input logic [1:0] a,
                     input logic [63:0] din, input logic ro, input logic pol,
                     input logic si, input logic [63:0] di, input logic so,
                     input logic ri, input logic [63:0] ndo,
                     input logic [63:0] dout);
    vec_t v;
    v = '{en, we, a, din, ro, pol, si, di, so, ri, ndo, dout};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, input logic we, input logic [1:0] a,
                       input logic [63:0] din, input logic ro, input logic pol,
                       input logic si, input logic [63:0] di);
    nicEn = en; nicWrEn = we; addr = a; d_in = din;
    net_ro = ro; net_polarity = pol; net_si = si; net_di = di;
  endtask

  logic [63:0] f1, f2, e1, e2, ones, z;

  initial begin
    checks = 0;
    passes = 0;
    f1   = make_flit(1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 48'h0);
    f2   = 64'h4000_0000_0000_0055;
    e1   = 64'h8003_0000_0000_00AB;
    e2   = 64'h0000_0000_0000_1234;
    ones = '1;
    z    = '0;

    reset = 1'b0;
    drive(0, 0, 2'b00, z, 0, 0, 0, z);
    #2 reset = 1'b1;
    #1;
    check("reset net_so", {63'b0, net_so}, 64'd0);
    check("reset net_ri", {63'b0, net_ri}, 64'd1);
    check("reset d_out", d_out, z);
    check("reset net_do", net_do, z);
    @(negedge clk);
    reset = 1'b0;

    //   en we addr din  ro pol si di  | so ri net_do d_out
    // inject
    add(0,0,2'b00,z,   1,1,0,z,   0,1,z, z);
    add(1,0,2'b11,z,   1,1,0,z,   0,1,z, z);
    add(1,1,2'b10,f1,  1,1,0,z,   0,1,z, z);
    add(1,0,2'b11,z,   1,1,0,z,   1,1,f1,64'd1);
    add(1,0,2'b11,z,   1,1,0,z,   0,1,f1,z);
    // polarity gate
    add(1,1,2'b10,f1,  1,0,0,z,   0,1,f1,z);
    add(1,0,2'b11,z,   1,0,0,z,   0,1,f1,64'd1);
    add(0,0,2'b00,z,   1,0,0,z,   0,1,f1,64'd1);
    add(0,0,2'b00,z,   1,0,0,z,   0,1,f1,64'd1);
    add(0,0,2'b00,z,   1,0,0,z,   0,1,f1,64'd1);
    add(1,0,2'b11,z,   1,0,0,z,   0,1,f1,64'd1);
    add(0,0,2'b00,z,   1,1,0,z,   1,1,f1,64'd1);
    add(1,0,2'b11,z,   1,1,0,z,   0,1,f1,z);
    // backpressure, second write dropped
    add(1,1,2'b10,f1,  0,1,0,z,   0,1,f1,z);
    add(0,0,2'b00,z,   0,1,0,z,   0,1,f1,z);
    add(1,1,2'b10,f2,  0,1,0,z,   0,1,f1,z);
    add(0,0,2'b00,z,   0,1,0,z,   0,1,f1,z);
    add(1,0,2'b11,z,   0,1,0,z,   0,1,f1,64'd1);
    add(0,0,2'b00,z,   1,1,0,z,   1,1,f1,64'd1);
    add(1,0,2'b11,z,   1,1,0,z,   0,1,f1,z);
    // eject, read-vs-strobe collision, overflow guard
    add(0,0,2'b00,z,   0,1,1,e1,  0,1,f1,z);
    add(1,0,2'b01,z,   0,1,0,z,   0,0,f1,64'd1);
    add(1,0,2'b00,z,   0,1,1,e2,  0,0,f1,e1);
    add(0,0,2'b00,z,   0,1,1,e2,  0,1,f1,e1);
    add(0,0,2'b00,z,   0,1,1,e1,  0,0,f1,e1);
    add(1,0,2'b00,z,   0,1,0,z,   0,0,f1,e2);
    add(1,0,2'b01,z,   0,1,0,z,   0,1,f1,z);
    add(1,0,2'b00,z,   0,1,0,z,   0,1,f1,e2);
    add(1,0,2'b10,z,   0,1,0,z,   0,1,f1,z);
    // writes to read-only registers ignored
    add(1,1,2'b00,f2,  0,1,0,z,   0,1,f1,z);
    add(1,0,2'b00,z,   0,1,0,z,   0,1,f1,e2);
    add(1,1,2'b11,ones,0,1,0,z,   0,1,f1,e2);
    add(1,0,2'b11,z,   0,1,0,z,   0,1,f1,z);
    // send and write in the same cycle: write dropped
    add(1,1,2'b10,f2,  1,0,0,z,   0,1,f1,z);
    add(1,1,2'b10,f1,  1,0,0,z,   1,1,f2,z);
    add(1,0,2'b11,z,   1,0,0,z,   0,1,f2,z);
    // status read during a send returns pre-edge 1
    add(1,1,2'b10,f2,  0,0,0,z,   0,1,f2,z);
    add(1,0,2'b11,z,   1,0,0,z,   1,1,f2,64'd1);
    add(1,0,2'b11,z,   1,0,0,z,   0,1,f2,z);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].din, vecs[i].ro,
            vecs[i].pol, vecs[i].si, vecs[i].di);
      #1;
      check($sformatf("v%0d net_so", i), {63'b0, net_so}, {63'b0, vecs[i].exp_so});
      check($sformatf("v%0d net_ri", i), {63'b0, net_ri}, {63'b0, vecs[i].exp_ri});
      check($sformatf("v%0d net_do", i), net_do, vecs[i].exp_ndo);
      @(posedge clk);
      #1;
      check($sformatf("v%0d d_out", i), d_out, vecs[i].exp_dout);
    end

    // Asynchronous reset mid-transfer with both buffers full and d_out nonzero.
    @(negedge clk);
    drive(1, 1, 2'b10, f1, 0, 1, 1, e1);
    @(negedge clk);
    drive(1, 0, 2'b01, z, 0, 1, 0, z);
    @(negedge clk);
    drive(0, 0, 2'b00, z, 1, 1, 0, z);
    #1;
    check("pre-reset net_so", {63'b0, net_so}, 64'd1);
    check("pre-reset net_ri", {63'b0, net_ri}, 64'd0);
    check("pre-reset d_out", d_out, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async net_so", {63'b0, net_so}, 64'd0);
    check("async net_ri", {63'b0, net_ri}, 64'd1);
    check("async d_out", d_out, z);
    check("async net_do", net_do, z);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 2'b01, z, 1, 1, 0, z);
    @(posedge clk);
    #1 check("post-reset in stat", d_out, z);
    @(negedge clk);
    drive(1, 0, 2'b11, z, 1, 1, 0, z);
    @(posedge clk);
    #1 check("post-reset out stat", d_out, z);
    @(negedge clk);
    drive(1, 0, 2'b00, z, 1, 1, 0, z);
    @(posedge clk);
    #1 check("post-reset in buf", d_out, z);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
